// File: rtl/mem_access_stage.sv
// Memory access stage: passes ALU results to writeback and runs loads/stores over a req/ack data port.
// Define MEM_ACCESS_STATS_EN to enable the load/store/stall/error counters; otherwise they read as zero.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int PCSIZE = 16,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [2:0]        ex_funct3,
  input  logic [PCSIZE-1:0] ex_pc,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [PCSIZE-1:0] wb_pc,
  output logic              lsu_err,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_errs
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [PCSIZE-1:0] wb_pc_q, wb_pc_d;
  logic              lsu_err_q, lsu_err_d;
  logic [4:0]        rd_q, rd_d;
  logic [PCSIZE-1:0] pc_q, pc_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              regwrite_q, regwrite_d;
  logic              isLoad_q, isLoad_d;

  logic              accept, isMem, funcOk, misaligned, accErr;
  logic [1:0]        off;
  logic [3:0]        laneBe;
  logic [XLEN-1:0]   storeData, loadWord, loadData;

  assign ex_ready = (state_q == IDLE);
  assign accept   = ex_valid & ex_ready;
  assign isMem    = ex_memread | ex_memwrite;
  assign off      = ex_result[1:0];

  // Decode legality, alignment and byte lanes of the incoming access.
  always_comb begin
    funcOk     = 1'b0;
    misaligned = 1'b0;
    case (ex_funct3)
      3'b000: funcOk = 1'b1;
      3'b001: begin funcOk = 1'b1; misaligned = off[0]; end
      3'b010: begin funcOk = 1'b1; misaligned = |off; end
      3'b100: funcOk = ex_memread;
      3'b101: begin funcOk = ex_memread; misaligned = off[0]; end
      default: funcOk = 1'b0;
    endcase
    accErr = (ex_memread & ex_memwrite) | ~funcOk | misaligned;
    case (ex_funct3[1:0])
      2'b00: begin laneBe = 4'b0001 << off;              storeData = {4{ex_rs2[7:0]}};  end
      2'b01: begin laneBe = off[1] ? 4'b1100 : 4'b0011;  storeData = {2{ex_rs2[15:0]}}; end
      default: begin laneBe = 4'b1111;                   storeData = ex_rs2;            end
    endcase
  end

  always_comb begin
    loadWord = dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  loadData = {{24{loadWord[7]}}, loadWord[7:0]};
      3'b001:  loadData = {{16{loadWord[15]}}, loadWord[15:0]};
      3'b100:  loadData = {24'd0, loadWord[7:0]};
      3'b101:  loadData = {16'd0, loadWord[15:0]};
      default: loadData = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    dmem_be_d     = dmem_be_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = wb_regwrite_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_pc_d       = wb_pc_q;
    lsu_err_d     = 1'b0;
    rd_d          = rd_q;
    pc_d          = pc_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    regwrite_d    = regwrite_q;
    isLoad_d      = isLoad_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!isMem) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = ex_result;
            wb_rd_d       = ex_rd;
            wb_regwrite_d = ex_regwrite;
            wb_pc_d       = ex_pc;
          end else if (accErr) begin
            wb_valid_d    = 1'b1;
            lsu_err_d     = 1'b1;
            wb_regwrite_d = 1'b0;
            wb_rd_d       = ex_rd;
            wb_data_d     = ex_result;
            wb_pc_d       = ex_pc;
          end else begin
            state_d      = WAIT;
            rd_d         = ex_rd;
            pc_d         = ex_pc;
            funct3_d     = ex_funct3;
            off_d        = off;
            regwrite_d   = ex_regwrite;
            isLoad_d     = ex_memread;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_memwrite;
            dmem_addr_d  = {ex_result[XLEN-1:2], 2'b00};
            dmem_be_d    = laneBe;
            dmem_wdata_d = ex_memwrite ? storeData : '0;
          end
        end
      end
      WAIT: begin
        // Request fields stay frozen until the memory acknowledges.
        if (dmem_ack) begin
          state_d       = IDLE;
          dmem_req_d    = 1'b0;
          dmem_we_d     = 1'b0;
          dmem_be_d     = 4'b0000;
          dmem_addr_d   = '0;
          dmem_wdata_d  = '0;
          wb_valid_d    = 1'b1;
          wb_rd_d       = rd_q;
          wb_pc_d       = pc_q;
          wb_regwrite_d = isLoad_q & regwrite_q;
          wb_data_d     = isLoad_q ? loadData : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      dmem_be_q     <= 4'b0000;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      wb_pc_q       <= '0;
      lsu_err_q     <= 1'b0;
      rd_q          <= '0;
      pc_q          <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      regwrite_q    <= 1'b0;
      isLoad_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      dmem_be_q     <= dmem_be_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_pc_q       <= wb_pc_d;
      lsu_err_q     <= lsu_err_d;
      rd_q          <= rd_d;
      pc_q          <= pc_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      regwrite_q    <= regwrite_d;
      isLoad_q      <= isLoad_d;
    end
  end

  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dmem_be     = dmem_be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_pc       = wb_pc_q;
  assign lsu_err     = lsu_err_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stat_loads_q, stat_stores_q, stat_stall_q, stat_errs_q;
  logic        ackInWait;

  assign ackInWait = (state_q == WAIT) & dmem_ack;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_stall_q  <= '0;
      stat_errs_q   <= '0;
    end else begin
      if (ackInWait & isLoad_q)              stat_loads_q  <= stat_loads_q + 32'd1;
      if (ackInWait & ~isLoad_q)             stat_stores_q <= stat_stores_q + 32'd1;
      if ((state_q == WAIT) & ~dmem_ack)     stat_stall_q  <= stat_stall_q + 32'd1;
      if (lsu_err_d)                         stat_errs_q   <= stat_errs_q + 32'd1;
    end
  end

  assign stat_loads        = stat_loads_q;
  assign stat_stores       = stat_stores_q;
  assign stat_stall_cycles = stat_stall_q;
  assign stat_errs         = stat_errs_q;
`else
  assign stat_loads        = '0;
  assign stat_stores       = '0;
  assign stat_stall_cycles = '0;
  assign stat_errs         = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected writebacks and memory requests,
// negedge monitors pop and compare them; a small responder plays data memory with a set ack delay.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = '0;
  logic [31:0] ex_rs2 = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_regwrite = 1'b0;
  logic        ex_memread = 1'b0;
  logic        ex_memwrite = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [15:0] ex_pc = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_regwrite, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [15:0] wb_pc;
  logic [31:0] stat_loads, stat_stores, stat_stall_cycles, stat_errs;

  mem_access_stage #(.PCSIZE(16), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .lsu_err(lsu_err),
    .stat_loads(stat_loads), .stat_stores(stat_stores),
    .stat_stall_cycles(stat_stall_cycles), .stat_errs(stat_errs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwrite;
    logic [15:0] pc;
    logic        err;
    logic        chkData;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  wb_exp_t     wbQ[$];
  mem_exp_t    memQ[$];
  wb_exp_t     wbE;
  mem_exp_t    curMem;
  int          checks = 0;
  int          passes = 0;
  int          negCount = 0;
  int          ackDelay = 1;
  int          reqCycles = 0;
  logic [31:0] rdataCfg = '0;
  logic        forceAck = 1'b0;
  logic        inWait = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Data memory model: acknowledges on the ackDelay-th cycle of a request.
  always @(negedge clk) begin
    if (dmem_req) reqCycles++;
    else reqCycles = 0;
    dmem_ack   = forceAck || (dmem_req && reqCycles == ackDelay);
    dmem_rdata = rdataCfg;
  end

  // Monitor: writeback scoreboard plus request contents and stability.
  always @(negedge clk) begin
    negCount++;
    if (!rst_n) begin
      inWait = 1'b0;
    end else begin
      if (wb_valid) begin
        if (wbQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL wb_unexpected: got wb_valid=1 expected no retirement (pc 0x%04h)", wb_pc);
        end else begin
          wbE = wbQ.pop_front();
          checkOutput("wb_cycle", negCount, wbE.cyc);
          checkOutput("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, wbE.regwrite});
          checkOutput("wb_pc", {16'd0, wb_pc}, {16'd0, wbE.pc});
          checkOutput("lsu_err", {31'd0, lsu_err}, {31'd0, wbE.err});
          if (wbE.chkData) begin
            checkOutput("wb_data", wb_data, wbE.data);
            checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, wbE.rd});
          end
        end
      end else if (lsu_err) begin
        checks++;
        $display("[TB] FAIL lsu_err_alone: got lsu_err=1 wb_valid=0 expected both high together");
      end
      if (dmem_req) begin
        checkOutput("ex_ready_in_wait", {31'd0, ex_ready}, 32'd0);
        if (!inWait) begin
          if (memQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL dmem_unexpected: got dmem_req=1 addr 0x%08h expected no request", dmem_addr);
            curMem = '{dmem_we, dmem_addr, dmem_be, dmem_wdata};
          end else begin
            curMem = memQ.pop_front();
          end
          inWait = 1'b1;
        end
        checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, curMem.we});
        checkOutput("dmem_addr", dmem_addr, curMem.addr);
        checkOutput("dmem_be", {28'd0, dmem_be}, {28'd0, curMem.be});
        checkOutput("dmem_wdata", dmem_wdata, curMem.wdata);
      end else begin
        inWait = 1'b0;
      end
    end
  end

  task automatic applyStimulus(
    input logic [31:0] result, input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
    input logic mr, input logic mw, input logic [2:0] f3, input logic [15:0] pc,
    input int delay, input logic [31:0] rdata,
    input logic [31:0] expData, input logic expRw, input logic expErr, input logic chkData,
    input logic expMem, input logic expWe, input logic [3:0] expBe, input logic [31:0] expWdata);
    int guard;
    wb_exp_t w;
    mem_exp_t m;
    guard = 0;
    @(negedge clk);
    while (!ex_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ex_ready) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got ex_ready=0 for 200 cycles expected 1 (pc 0x%04h)", pc);
      return;
    end
    ackDelay    = delay;
    rdataCfg    = rdata;
    ex_result   = result;
    ex_rs2      = rs2;
    ex_rd       = rd;
    ex_regwrite = rw;
    ex_memread  = mr;
    ex_memwrite = mw;
    ex_funct3   = f3;
    ex_pc       = pc;
    ex_valid    = 1'b1;
    @(posedge clk);
    w = '{expData, rd, expRw, pc, expErr, chkData, negCount + (expMem ? delay + 1 : 1)};
    wbQ.push_back(w);
    if (expMem) begin
      m = '{expWe, {result[31:2], 2'b00}, expBe, expWdata};
      memQ.push_back(m);
    end
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected $finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    checkOutput("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    checkOutput("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_pc", {16'd0, wb_pc}, 32'd0);
    checkOutput("rst_lsu_err", {31'd0, lsu_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // result, rs2, rd, rw, mr, mw, f3, pc, delay, rdata, expData, expRw, expErr, chkData, expMem, we, be, wdata
    applyStimulus(32'h1234, 0, 5, 1, 0, 0, 3'b000, 16'h0010, 1, 0, 32'h1234, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(32'h1234, 0, 5, 1, 0, 0, 3'b000, 16'h0014, 1, 0, 32'h1234, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(32'h1234, 0, 5, 1, 0, 0, 3'b000, 16'h0018, 1, 0, 32'h1234, 1, 0, 1, 0, 0, 0, 0);
    idleCycles(2);
    applyStimulus(32'h103, 0, 6, 1, 1, 0, 3'b000, 16'h0020, 3, 32'h80FF_FF00, 32'hFFFF_FF80, 1, 0, 1, 1, 0, 4'b1000, 0);
    applyStimulus(32'h103, 0, 6, 1, 1, 0, 3'b100, 16'h0024, 3, 32'h80FF_FF00, 32'h0000_0080, 1, 0, 1, 1, 0, 4'b1000, 0);
    applyStimulus(32'h202, 32'hAAAA_BEEF, 9, 1, 0, 1, 3'b001, 16'h0028, 1, 0, 0, 0, 0, 0, 1, 1, 4'b1100, 32'hBEEF_BEEF);
    applyStimulus(32'h101, 0, 4, 1, 1, 0, 3'b010, 16'h002C, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(32'hCAFE, 0, 7, 1, 0, 0, 3'b000, 16'h0030, 1, 0, 32'hCAFE, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(32'h102, 0, 8, 1, 1, 0, 3'b001, 16'h0034, 2, 32'h8001_1234, 32'hFFFF_8001, 1, 0, 1, 1, 0, 4'b1100, 0);
    applyStimulus(32'h100, 0, 8, 1, 1, 0, 3'b101, 16'h0038, 1, 32'h8001_9234, 32'h0000_9234, 1, 0, 1, 1, 0, 4'b0011, 0);
    applyStimulus(32'h104, 0, 10, 1, 1, 0, 3'b010, 16'h003C, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 1, 1, 0, 4'b1111, 0);
    applyStimulus(32'h301, 32'h1234_5678, 0, 0, 0, 1, 3'b000, 16'h0040, 2, 0, 0, 0, 0, 0, 1, 1, 4'b0010, 32'h7878_7878);
    applyStimulus(32'h400, 32'h0BAD_F00D, 0, 0, 0, 1, 3'b010, 16'h0044, 1, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 32'h0BAD_F00D);
    applyStimulus(32'h500, 0, 3, 1, 1, 0, 3'b011, 16'h0048, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(32'h500, 32'h1, 3, 1, 1, 1, 3'b010, 16'h004C, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(32'h502, 32'h1, 3, 0, 0, 1, 3'b010, 16'h0050, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idleCycles(3);

    // Reset while a request is outstanding: nothing may retire, late acks are ignored.
    applyStimulus(32'h600, 0, 2, 1, 1, 0, 3'b010, 16'h0060, 1000, 0, 0, 1, 0, 1, 1, 0, 4'b1111, 0);
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("wait_dmem_req", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstwait_dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rstwait_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rstwait_ex_ready", {31'd0, ex_ready}, 32'd1);
    wbQ.delete();
    memQ.delete();
    forceAck = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postrst_ex_ready", {31'd0, ex_ready}, 32'd1);
    checkOutput("postrst_dmem_req", {31'd0, dmem_req}, 32'd0);
    forceAck = 1'b0;
    idleCycles(1);

    // Counter scenario after a clean reset: 2 loads (one with 4 stall cycles), 1 store, 1 error.
    applyStimulus(32'h10, 0, 11, 1, 1, 0, 3'b000, 16'h0070, 1, 32'h0000_00AA, 32'hFFFF_FFAA, 1, 0, 1, 1, 0, 4'b0001, 0);
    applyStimulus(32'h20, 0, 12, 1, 1, 0, 3'b010, 16'h0074, 5, 32'h1122_3344, 32'h1122_3344, 1, 0, 1, 1, 0, 4'b1111, 0);
    applyStimulus(32'h30, 32'h55, 0, 0, 0, 1, 3'b010, 16'h0078, 1, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 32'h55);
    applyStimulus(32'h31, 0, 13, 1, 1, 0, 3'b001, 16'h007C, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idleCycles(3);
`ifdef MEM_ACCESS_STATS_EN
    checkOutput("stat_loads", stat_loads, 32'd2);
    checkOutput("stat_stores", stat_stores, 32'd1);
    checkOutput("stat_stall_cycles", stat_stall_cycles, 32'd4);
    checkOutput("stat_errs", stat_errs, 32'd1);
`else
    checkOutput("stat_loads_tied", stat_loads, 32'd0);
    checkOutput("stat_stores_tied", stat_stores, 32'd0);
    checkOutput("stat_stall_tied", stat_stall_cycles, 32'd0);
    checkOutput("stat_errs_tied", stat_errs, 32'd0);
`endif

    guard = 0;
    while ((wbQ.size() != 0 || memQ.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (wbQ.size() != 0 || memQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: got %0d writebacks and %0d requests pending expected 0", wbQ.size(), memQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage between the execute stage (ALU result, store data, control) and writeback.
- Accepts one instruction at a time from execute over a valid/ready handshake.
- Loads and stores go to data memory over a req/ack handshake, with byte lanes, sign/zero extension and misalignment detection.
- Non-memory instructions pass the ALU result through to writeback with 1-cycle latency.

Parameters:
- PCSIZE, 16, width of PC carried alongside the instruction.
- XLEN, 32, data/address width (only 32 supported).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept (state IDLE).
- ex_result  in  32  ALU result: memory address or writeback value.
- ex_rs2  in  32  store data.
- ex_rd  in  5  destination register.
- ex_regwrite  in  1  instruction writes rd.
- ex_memread  in  1  load.
- ex_memwrite  in  1  store.
- ex_funct3  in  3  access size/signedness.
- ex_pc  in  PCSIZE  instruction PC.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=write.
- dmem_addr  out  32  word-aligned address ({ex_result[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  memory completes the request this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ack=1.
- wb_valid  out  1  one-cycle pulse: writeback fields valid.
- wb_regwrite  out  1  writeback enable.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- wb_pc  out  PCSIZE  PC of retiring instruction.
- lsu_err  out  1  one-cycle pulse: misaligned or illegal access.

Behaviour:
- Reset (async, immediate): state IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0; wb_valid=0, wb_regwrite=0, wb_rd=0, wb_data=0, wb_pc=0; lsu_err=0. A request in flight is abandoned; a late dmem_ack is ignored.
- FSM states: IDLE, WAIT.
- ex_ready=1 only in IDLE. An instruction is accepted when ex_valid & ex_ready at a rising edge.
- Accepted, ex_memread=0 and ex_memwrite=0: next cycle wb_valid=1, wb_data=ex_result, wb_rd/wb_regwrite/wb_pc registered. Stay IDLE.
- Accepted, valid memory op: latch rd, pc, funct3, addr[1:0] and regwrite; go to WAIT. dmem_req=1 from the next cycle.
- In WAIT, dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable until dmem_ack=1.
- On the edge sampling dmem_ack=1 in WAIT: go to IDLE; next cycle wb_valid=1 and dmem_req=0.
- Minimum memory-op latency is 2 cycles from accept to wb_valid (ack in first WAIT cycle). dmem_ack while not in WAIT is ignored.
- Loads: byte = dmem_rdata >> (8*addr[1:0]).
  - LB 000: sign-extend byte[7:0].
  - LH 001: sign-extend [15:0].
  - LW 010: full word.
  - LBU 100: zero-extend byte.
  - LHU 101: zero-extend half.
  - wb_regwrite = latched regwrite.
- Stores:
  - SB 000: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH 001: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW 010: be=4'b1111, wdata=rs2.
  - wb_regwrite=0 for all stores.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0), any other funct3, or ex_memread=1 and ex_memwrite=1 together:
  - No memory request; stay IDLE.
  - Next cycle lsu_err=1 and wb_valid=1 with wb_regwrite=0, wb_pc=ex_pc.
- Writeback never stalls. wb_valid and lsu_err are high for exactly one cycle per event.
- Back-to-back non-memory instructions retire once per cycle.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined: adds 32-bit output counters stat_loads, stat_stores, stat_stall_cycles and stat_errs.
  - stat_loads / stat_stores: incremented on each completed load/store (at ack).
  - stat_stall_cycles: incremented each WAIT cycle with dmem_ack=0.
  - stat_errs: incremented per lsu_err.
  - All counters reset to 0 and wrap at 2^32.
- Undefined: the four ports still exist, are tied to 0, and no counter logic is synthesized.

Test Plan:
- ALU passthrough: ex_result=0x1234, rd=5, regwrite=1, no memop, 3 back-to-back -> wb_valid every cycle starting 1 cycle after accept, wb_data=0x1234, wb_rd=5, dmem_req never 1.
- LB sign: addr=0x103, funct3=000, ack after 3 cycles, rdata=0x80FF_FF00 -> dmem_addr=0x100 held 3 cycles, ex_ready=0 meanwhile, wb_data=0xFFFF_FF80; same stimulus with LBU -> 0x0000_0080.
- SH upper: addr=0x202, rs2=0xAAAA_BEEF, funct3=001 -> dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, wb_regwrite=0.
- Misaligned LW at addr=0x101 -> no dmem_req, lsu_err=1 and wb_valid=1 for one cycle, wb_regwrite=0; next instruction accepted the following cycle.
- Reset mid-WAIT: assert rst_n=0 while dmem_req=1 -> dmem_req=0 immediately, no wb_valid; after release, ack=1 ignored and ex_ready=1.
- With MEM_ACCESS_STATS_EN: 2 loads (one with 4 wait cycles), 1 store, 1 misaligned -> stat_loads=2, stat_stores=1, stat_stall_cycles=4, stat_errs=1.
